// File: rtl/cam_soc_from_hw_port.sv
// Purpose : Avalon-MM status input port with synchronizer, edge capture and masked level interrupt.
// Latency : DATA at E(SYNC_STAGES-1), EDGE_CAP at E(SYNC_STAGES), irq at E(SYNC_STAGES+1) after stage 1 samples.
// Backpr. : none; zero-wait-state slave, every access completes in the cycle it is presented.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave: 0 DATA (RO), 1 EDGE_CFG (RW [1:0]),
//   write_n, writedata,   2 IRQ_MASK (RW), 3 EDGE_CAP (RW1C)
//   readdata              combinational read of the register picked by address
//   in_port               asynchronous hardware status inputs
//   irq                   registered level interrupt, |(EDGE_CAP & IRQ_MASK)
module cam_soc_from_hw_port #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_CFG = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam logic [1:0] CFG_RISE = 2'b00;
  localparam logic [1:0] CFG_FALL = 2'b01;
  localparam logic [1:0] CFG_BOTH = 2'b10;

  // Arm counter needs to reach SYNC_STAGES (at most 3), two bits suffice.
  localparam int             CNT_W    = 2;
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       edge_cfg;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_cap_nxt;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [CNT_W-1:0] arm_cnt;
  logic             arm;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en  = chipselect && !write_n;
  assign sync_q = sync_r[SYNC_STAGES-1];

  // Upper writedata bits have no destination when WIDTH < 32.
  assign unused_wd = ^writedata;

  // Synchronizer chain; index 0 is the stage that samples in_port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      prev_q <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_q;
    end
  end

  // Hold off capture until the chain has flushed whatever it held through
  // reset, so inputs already high at release do not look like edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
      arm     <= 1'b0;
    end else if (!arm) begin
      if (arm_cnt == ARM_LAST) begin
        arm <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rise     = ~prev_q & sync_q;
    fall     = prev_q & ~sync_q;
    edge_hit = '0;
    case (edge_cfg)
      CFG_RISE: edge_hit = rise;
      CFG_FALL: edge_hit = fall;
      CFG_BOTH: edge_hit = rise | fall;
      default:  edge_hit = '0;
    endcase
    if (!arm) begin
      edge_hit = '0;
    end
  end

  // Set is OR'd in after the W1C mask so a simultaneous edge wins.
  always_comb begin
    edge_cap_nxt = edge_cap | edge_hit;
    if (wr_en && address == ADDR_EDGE_CAP) begin
      edge_cap_nxt = (edge_cap & ~writedata[WIDTH-1:0]) | edge_hit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cfg <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= edge_cap_nxt;
      irq      <= |(edge_cap & irq_mask);
      if (wr_en && address == ADDR_EDGE_CFG) begin
        edge_cfg <= writedata[1:0];
      end
      if (wr_en && address == ADDR_IRQ_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Read mux ignores chipselect so the value is stable for the whole access.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = sync_q;
      ADDR_EDGE_CFG: readdata[1:0]       = edge_cfg;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
      default:       readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_cam_soc_from_hw_port.sv
// Purpose : directed, self-checking bench for cam_soc_from_hw_port (WIDTH=16, SYNC_STAGES=2).
// Latency : expected values are hand-derived from the edge-numbered latency rules.
// Backpr. : none; bus accesses are single-cycle.
module tb_cam_soc_from_hw_port;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic        irq;

  int n_checks;
  int n_fail;

  cam_soc_from_hw_port #(
    .WIDTH(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Write lands on the next rising edge; returns 1 unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  logic [31:0] v;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 16'hFFFF;
    #23;

    // Reset state: every register reads zero, irq low.
    rd(2'd0, v); check("rst_data", v, 32'h0);
    rd(2'd1, v); check("rst_cfg", v, 32'h0);
    rd(2'd2, v); check("rst_mask", v, 32'h0);
    rd(2'd3, v); check("rst_cap", v, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // Release with inputs held high: DATA follows, arm suppresses capture.
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(1);
    rd(2'd0, v); check("sync_e0_data", v, 32'h0);
    tick(1);
    rd(2'd0, v); check("sync_e1_data", v, 32'h0000FFFF);
    tick(3);
    rd(2'd3, v); check("arm_supp_cap", v, 32'h0);
    check("arm_supp_irq", {31'b0, irq}, 32'h0);

    // Rising edge on bit0 with mask bit0; upper write bits are dropped.
    wr(2'd2, 32'hFFFF0001);
    rd(2'd2, v); check("mask_rb", v, 32'h00000001);
    in_port = 16'h0000;
    tick(4);
    rd(2'd3, v); check("fall_ign_rise", v, 32'h0);
    in_port = 16'h0001;
    tick(2);
    rd(2'd3, v); check("cap_e1", v, 32'h0);
    tick(1);
    rd(2'd3, v); check("cap_e2", v, 32'h00000001);
    check("irq_e2", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_e3", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h00000001);
    rd(2'd3, v); check("w1c_cap", v, 32'h0);
    check("irq_lag", {31'b0, irq}, 32'h1);
    tick(1);
    check("irq_clr", {31'b0, irq}, 32'h0);

    // Falling-edge mode.
    wr(2'd1, 32'h00000003);
    in_port = 16'h00F0;
    tick(4);
    wr(2'd1, 32'hFFFFFFFD);
    rd(2'd1, v); check("cfg_rb", v, 32'h00000001);
    rd(2'd3, v); check("cfg_none_cap", v, 32'h0);
    in_port = 16'h0000;
    tick(3);
    rd(2'd3, v); check("fall_cap", v, 32'h000000F0);
    wr(2'd3, 32'h000000F0);
    in_port = 16'h00F0;
    tick(4);
    rd(2'd3, v); check("fall_no_rise", v, 32'h0);

    // Either-edge mode recaptures the same rise.
    wr(2'd1, 32'h00000003);
    in_port = 16'h0000;
    tick(4);
    wr(2'd1, 32'h00000002);
    in_port = 16'h00F0;
    tick(3);
    rd(2'd3, v); check("both_cap", v, 32'h000000F0);
    check("both_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h0000FFFF);
    rd(2'd3, v); check("clr_all", v, 32'h0);

    // Set beats simultaneous clear on bit3.
    in_port = 16'h00F8;
    tick(3);
    rd(2'd3, v); check("bit3_cap", v, 32'h00000008);
    in_port = 16'h00F0;
    tick(2);
    wr(2'd3, 32'h00000008);
    rd(2'd3, v); check("set_wins", v, 32'h00000008);
    wr(2'd3, 32'h00000008);
    rd(2'd3, v); check("plain_clr", v, 32'h0);

    // Masking, then late mask enable, then capture disabled.
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h0);
    in_port = 16'h00E0;
    tick(4);
    in_port = 16'h00F0;
    tick(3);
    rd(2'd3, v); check("bit4_cap", v, 32'h00000010);
    tick(2);
    check("irq_mask0", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h00000010);
    check("irq_mask_lag", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq_mask_on", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h00000003);
    in_port = 16'h0000; tick(3);
    in_port = 16'hFFFF; tick(3);
    in_port = 16'h1234; tick(3);
    rd(2'd3, v); check("none_cap", v, 32'h00000010);
    rd(2'd0, v); check("none_data", v, 32'h00001234);
    check("irq_held", {31'b0, irq}, 32'h1);

    // Asynchronous reset mid-cycle while irq is high.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, irq}, 32'h0);
    rd(2'd3, v); check("arst_cap", v, 32'h0);
    rd(2'd2, v); check("arst_mask", v, 32'h0);
    rd(2'd1, v); check("arst_cfg", v, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    rd(2'd0, v); check("post_rst_data", v, 32'h00001234);
    wr(2'd0, 32'h0000FFFF);
    rd(2'd0, v); check("data_ro", v, 32'h00001234);
    tick(3);
    rd(2'd3, v); check("rearm_supp", v, 32'h0);
    in_port = 16'h1235;
    tick(3);
    rd(2'd3, v); check("rearm_cap", v, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
